bcd_display_controller: RTL

Sequential binary-to-BCD converter and multiplexed seven-segment scanner for the counter display path. It accepts a binary count on a load strobe and runs an iterative shift-and-add-3 (double-dabble) sequence, one bit per clock. It commits the finished digits to a stable display register, then time-multiplexes those digits onto a common-anode seven-segment display. It sits between the counter and the board's segment/digit pins, and replaces a wide combinational converter with a small W-cycle engine.

---
 rtl/bcd_display_controller.sv | 117 +++++++++++
 1 files changed

// File: rtl/bcd_display_controller.sv
// bcd_display_controller: serial double-dabble binary-to-BCD converter feeding a multiplexed 7-seg scanner
// Ports: clk, rst (sync, active-high); value/load start a conversion; busy, done (1-cycle pulse) and
//        bcd_out report the committed result; seg {g..a} and dig_en (bit 0 = ones) are active-low.
// Define BCD_BLANK_LEADING_EN to blank leading zero digits (digit 0 is always shown).
module bcd_display_controller #(
    parameter int W        = 16,
    parameter int DIGITS   = 5,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          value,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_en
);
    localparam int SW = 4*DIGITS + W;
    localparam int CW = $clog2(W + 1);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    state_t              state_q, state_d;
    logic [SW-1:0]       sr_q, sr_d, sr_t;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d, idx_n;
    logic [3:0]          nib_q, nib_d, raw;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                tick;
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        sr_t    = sr_q;
        for (int i = 0; i < DIGITS; i++)
            if (sr_t[W+4*i +: 4] > 4'd4) sr_t[W+4*i +: 4] = sr_t[W+4*i +: 4] + 4'd3;
        case (state_q)
            IDLE: if (load) begin
                sr_d    = {{4*DIGITS{1'b0}}, value};
                cnt_d   = CW'(W);
                busy_d  = 1'b1;
                state_d = CONVERT;
            end
            CONVERT: begin
                sr_d    = sr_t << 1;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CW'(1) ? COMMIT : CONVERT;
            end
            COMMIT: begin
                bcd_d   = sr_q[SW-1 -: 4*DIGITS];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // The digit nibble is captured at the index advance, so a result committed on the
    // same edge is only picked up at the following advance.
    always_comb begin
        tick  = pre_q == PW'(SCAN_DIV - 1);
        pre_d = tick ? '0 : pre_q + 1'b1;
        idx_n = idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
        idx_d = tick ? idx_n : idx_q;
        raw   = 4'(bcd_q >> (4*idx_n));
`ifdef BCD_BLANK_LEADING_EN
        nib_d = tick ? ((idx_n != '0 && (bcd_q >> (4*idx_n)) == '0) ? 4'hF : raw) : nib_q;
`else
        nib_d = tick ? raw : nib_q;
`endif
        seg_d = GLYPH[nib_q];
        dig_d = ~(DIGITS'(1) << idx_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            nib_q   <= '0;
            seg_q   <= 7'h40;
            dig_q   <= ~DIGITS'(1);
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            nib_q   <= nib_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end
    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign seg     = seg_q;
    assign dig_en  = dig_q;
endmodule
